// File: rtl/m_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : m_muldiv_if
//  Description : Operand, mthi/mtlo and result bundle of the iterative
//                multiply/divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface m_muldiv_if;
  logic        w_start;
  logic [1:0]  w_op;
  logic [31:0] w_rs;
  logic [31:0] w_rt;
  logic        w_we_hi;
  logic        w_we_lo;
  logic [31:0] w_wdata;
  logic        w_busy;
  logic        w_done;
  logic [31:0] w_hi;
  logic [31:0] w_lo;

  // Issuing side (core execute stage)
  modport master (
    output w_start, w_op, w_rs, w_rt, w_we_hi, w_we_lo, w_wdata,
    input  w_busy, w_done, w_hi, w_lo
  );

  // Multiply/divide unit
  modport slave (
    input  w_start, w_op, w_rs, w_rt, w_we_hi, w_we_lo, w_wdata,
    output w_busy, w_done, w_hi, w_lo
  );
endinterface
`default_nettype wire

// File: rtl/m_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : m_muldiv
//  Description : 32-iteration shift-add multiplier / restoring divider with
//                HI/LO result registers (MULT, MULTU, DIV, DIVU, mthi, mtlo).
//  Revision    : 1.0  initial release
// ============================================================================
module m_muldiv (
  input  wire logic   w_clk,
  input  wire logic   w_rst,
  m_muldiv_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_busy;
  logic        w_done;

  logic [31:0] r_a;        // |multiplicand| / |dividend|, dividend shifts left
  logic [31:0] r_b;        // |multiplier| (shifts right) / |divisor|
  logic [63:0] r_acc;      // product, or {remainder, quotient} while dividing
  logic [4:0]  r_count;
  logic        r_div;      // 1 = divide, 0 = multiply
  logic        r_neg_q;    // product / quotient must be negated
  logic        r_neg_r;    // remainder must be negated (dividend was negative)
  logic        r_div0;     // divide by zero
  logic [31:0] r_rs_raw;   // unmodified dividend for the divide-by-zero result
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_launch;
  logic        w_signed;
  logic [31:0] w_rs_abs;
  logic [31:0] w_rt_abs;
  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_launch = (r_state == S_IDLE) && bus.w_start;
  assign w_signed = bus.w_op[1];
  assign w_rs_abs = (w_signed && bus.w_rs[31]) ? (32'd0 - bus.w_rs) : bus.w_rs;
  assign w_rt_abs = (w_signed && bus.w_rt[31]) ? (32'd0 - bus.w_rt) : bus.w_rt;

  // Multiply step: add multiplicand into the top half when the current
  // multiplier bit is set, then shift the 65-bit {carry, acc} right by one.
  assign w_sum = {1'b0, r_acc[63:32]} + (r_b[0] ? {1'b0, r_a} : 33'd0);

  // Divide step: trial subtract of the divisor from {rem, next dividend bit}.
  // The remainder is always below the divisor, so when the trial succeeds the
  // difference fits in 32 bits and the low-32 subtraction is exact.
  assign w_shift = {r_acc[63:32], r_a[31]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[31:0] - r_b;

  // Sign correction applied in FIX
  assign w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
  assign w_quo  = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

  // Select the value that FIX commits to HI/LO
  always_comb begin
    w_res_hi = w_prod[63:32];
    w_res_lo = w_prod[31:0];
    if (r_div0) begin
      w_res_hi = r_rs_raw;
      w_res_lo = 32'hFFFF_FFFF;
    end else if (r_div) begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end
  end

  // State register
  always_ff @(posedge w_clk) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.w_start) w_state_nxt = S_RUN;
      end
      S_RUN:   if (r_count == 5'd31) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and HI/LO registers
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_acc    <= 64'd0;
      r_count  <= 5'd0;
      r_div    <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_rs_raw <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      // mthi/mtlo only while idle; a write on the launch edge still lands
      if (r_state == S_IDLE) begin
        if (bus.w_we_hi) r_hi <= bus.w_wdata;
        if (bus.w_we_lo) r_lo <= bus.w_wdata;
      end
      if (w_launch) begin
        r_a      <= w_rs_abs;
        r_b      <= w_rt_abs;
        r_acc    <= 64'd0;
        r_count  <= 5'd0;
        r_div    <= bus.w_op[0];
        r_neg_q  <= w_signed && (bus.w_rs[31] ^ bus.w_rt[31]);
        r_neg_r  <= w_signed && bus.w_rs[31];
        r_div0   <= bus.w_op[0] && (bus.w_rt == 32'd0);
        r_rs_raw <= bus.w_rs;
      end
      if (r_state == S_RUN) begin
        r_count <= r_count + 5'd1;
        if (r_div) begin
          r_acc[63:32] <= w_ge ? w_diff : w_shift[31:0];
          r_acc[31:0]  <= {r_acc[30:0], w_ge};
          r_a          <= {r_a[30:0], 1'b0};
        end else begin
          r_acc <= {w_sum, r_acc[31:1]};
          r_b   <= {1'b0, r_b[31:1]};
        end
      end
      if (r_state == S_FIX) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign bus.w_busy = w_busy;
  assign bus.w_done = w_done;
  assign bus.w_hi   = r_hi;
  assign bus.w_lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_m_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_muldiv
//  Description : Scoreboard bench for m_muldiv; directed vectors with
//                hand-computed results plus model-checked random operations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_m_muldiv;

  localparam logic [1:0] C_MULTU = 2'b00;
  localparam logic [1:0] C_DIVU  = 2'b01;
  localparam logic [1:0] C_MULT  = 2'b10;
  localparam logic [1:0] C_DIV   = 2'b11;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic w_clk = 1'b0;
  logic w_rst = 1'b1;
  int   r_cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  m_muldiv_if bus ();

  m_muldiv dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .bus   (bus)
  );

  always #5 w_clk = ~w_clk;

  // Free-running edge counter for latency checks
  always @(posedge w_clk) r_cyc <= r_cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  // Reference model, written from the instruction semantics
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] rs,
                                        input logic [31:0] rt);
    longint a;
    longint b;
    longint q;
    longint r;
    logic [63:0] res;
    if (op[0] && rt == 32'd0) return {rs, 32'hFFFF_FFFF};
    case (op)
      C_MULTU: res = {32'd0, rs} * {32'd0, rt};
      C_DIVU:  res = {rs % rt, rs / rt};
      C_MULT: begin
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        res = a * b;
      end
      default: begin
        if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
          res = {32'd0, 32'h8000_0000};
        end else begin
          a = longint'($signed(rs));
          b = longint'($signed(rt));
          q = a / b;
          r = a % b;
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Monitor: every done pulse must match the oldest pending expectation
  always @(negedge w_clk) begin
    if (bus.w_done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_done: got done=1 at cycle %0d, required no pending op", r_cyc);
      end else begin
        e = sb.pop_front();
        chk("result_hi", {32'd0, bus.w_hi}, {32'd0, e.hi});
        chk("result_lo", {32'd0, bus.w_lo}, {32'd0, e.lo});
        chk("done_latency", 64'(r_cyc), 64'(e.cyc));
      end
    end
  end

  // Drive one start (optionally with mthi/mtlo on the same edge)
  task automatic drive_start(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                             input logic we_hi, input logic we_lo, input logic [31:0] wd);
    @(negedge w_clk);
    bus.w_start = 1'b1;
    bus.w_op    = op;
    bus.w_rs    = rs;
    bus.w_rt    = rt;
    bus.w_we_hi = we_hi;
    bus.w_we_lo = we_lo;
    bus.w_wdata = wd;
    @(posedge w_clk);
    #1;
    bus.w_start = 1'b0;
    bus.w_we_hi = 1'b0;
    bus.w_we_lo = 1'b0;
    bus.w_rs    = ~rs;
    bus.w_rt    = ~rt;
  endtask

  // Accepted start: expectation is pushed; done is due 33 edges later
  task automatic issue(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input logic we_hi, input logic we_lo, input logic [31:0] wd);
    exp_t e;
    drive_start(op, rs, rt, we_hi, we_lo, wd);
    e.hi  = ehi;
    e.lo  = elo;
    e.cyc = r_cyc + 33;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge w_clk);
      if (bus.w_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_idle: got busy=1 after 100 cycles, required busy=0");
    end
  endtask

  task automatic mt_write(input logic we_hi, input logic we_lo, input logic [31:0] wd);
    @(negedge w_clk);
    bus.w_we_hi = we_hi;
    bus.w_we_lo = we_lo;
    bus.w_wdata = wd;
    @(posedge w_clk);
    #1;
    bus.w_we_hi = 1'b0;
    bus.w_we_lo = 1'b0;
  endtask

  // Directed vectors: op, rs, rt, HI, LO
  logic [1:0]  d_op [11] = '{C_MULTU, C_MULT, C_DIV, C_DIVU, C_DIV, C_DIV,
                             C_DIV, C_MULT, C_MULTU, C_DIVU, C_MULT};
  logic [31:0] d_rs [11] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000,
                             32'd7, 32'hFFFFFFFB, 32'h80000000, 32'h12345678, 32'hFFFFFFFF,
                             32'hFFFFFFFF};
  logic [31:0] d_rt [11] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFF,
                             32'hFFFFFFFE, 32'd0, 32'h80000000, 32'd0, 32'd1,
                             32'hFFFFFFFF};
  logic [31:0] d_hi [11] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100, 32'd0,
                             32'd1, 32'hFFFFFFFB, 32'h40000000, 32'd0, 32'd0, 32'd0};
  logic [31:0] d_lo [11] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                             32'hFFFFFFFD, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1};

  initial begin
    int d0;
    logic [63:0] m;
    logic [1:0]  rop;
    logic [31:0] rrs;
    logic [31:0] rrt;
    bus.w_start = 1'b0;
    bus.w_op    = 2'b00;
    bus.w_rs    = 32'd0;
    bus.w_rt    = 32'd0;
    bus.w_we_hi = 1'b0;
    bus.w_we_lo = 1'b0;
    bus.w_wdata = 32'd0;

    // Reset state
    repeat (3) @(posedge w_clk);
    #1 w_rst = 1'b0;
    @(negedge w_clk);
    chk("reset_busy", {63'd0, bus.w_busy}, 64'd0);
    chk("reset_done", {63'd0, bus.w_done}, 64'd0);
    chk("reset_hi", {32'd0, bus.w_hi}, 64'd0);
    chk("reset_lo", {32'd0, bus.w_lo}, 64'd0);

    // Directed arithmetic incl. divide-by-zero and signed overflow
    for (int i = 0; i < 11; i++) begin
      issue(d_op[i], d_rs[i], d_rt[i], d_hi[i], d_lo[i], 1'b0, 1'b0, 32'd0);
      wait_idle();
    end

    // Start while busy is ignored; exactly one done pulse
    d0 = done_cnt;
    issue(C_DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 1'b0, 1'b0, 32'd0);
    repeat (4) @(posedge w_clk);
    drive_start(C_MULTU, 32'd2, 32'd2, 1'b0, 1'b0, 32'd0);
    wait_idle();
    repeat (3) @(negedge w_clk);
    chk("single_done", 64'(done_cnt - d0), 64'd1);

    // Reset mid-operation abandons it
    drive_start(C_MULTU, 32'd5, 32'd6, 1'b0, 1'b0, 32'd0);
    repeat (9) @(posedge w_clk);
    @(negedge w_clk);
    w_rst = 1'b1;
    @(posedge w_clk);
    #1 w_rst = 1'b0;
    @(negedge w_clk);
    chk("midrst_busy", {63'd0, bus.w_busy}, 64'd0);
    chk("midrst_hi", {32'd0, bus.w_hi}, 64'd0);
    chk("midrst_lo", {32'd0, bus.w_lo}, 64'd0);
    d0 = done_cnt;
    repeat (40) @(negedge w_clk);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    issue(C_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 1'b0, 32'd0);
    wait_idle();

    // mthi/mtlo while idle
    mt_write(1'b0, 1'b1, 32'h1234);
    @(negedge w_clk);
    chk("mtlo_idle", {32'd0, bus.w_lo}, 64'h1234);
    chk("mtlo_hi_kept", {32'd0, bus.w_hi}, 64'd0);
    mt_write(1'b1, 1'b0, 32'hAAAA5555);
    @(negedge w_clk);
    chk("mthi_idle", {32'd0, bus.w_hi}, 64'hAAAA5555);
    mt_write(1'b1, 1'b1, 32'h11111111);
    @(negedge w_clk);
    chk("mt_both", {bus.w_hi, bus.w_lo}, 64'h11111111_11111111);

    // mtlo on the launch edge lands; mthi during RUN is ignored
    issue(C_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b1, 32'hCAFEBABE);
    @(negedge w_clk);
    chk("mtlo_at_start", {32'd0, bus.w_lo}, 64'hCAFEBABE);
    mt_write(1'b1, 1'b0, 32'hDEADBEEF);
    @(negedge w_clk);
    chk("mthi_busy_ignored", {32'd0, bus.w_hi}, 64'h11111111);
    wait_idle();

    // Random operations against the model
    for (int i = 0; i < 300; i++) begin
      rop = 2'($urandom_range(0, 3));
      rrs = $urandom;
      case ($urandom_range(0, 4))
        0:       rrt = 32'd0;
        1:       rrt = 32'($urandom_range(1, 20));
        2:       rrt = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
        default: rrt = $urandom;
      endcase
      m = model(rop, rrs, rrt);
      issue(rop, rrs, rrt, m[63:32], m[31:0], 1'b0, 1'b0, 32'd0);
      wait_idle();
    end

    repeat (5) @(negedge w_clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
